// File: rtl/npu_defines.sv
// Shared NPU host-interface definitions.
// Holds the host message codes carried on the item link and the 2-bit host opcode.
// Both the host-side master and the NPU-side item receiver import this package.
package npu_defines;

  // Message codes on the item link. The host master sends only BOOT, ENABLE_CORE,
  // READ_CR and WRITE_CR. The other codes travel from the NPU back to the host.
  typedef enum logic [3:0] {
    MsgBoot        = 4'd0,
    MsgBootDone    = 4'd1,
    MsgEnableCore  = 4'd2,
    MsgCoreEnabled = 4'd3,
    MsgReadCr      = 4'd8,
    MsgWriteCr     = 4'd9,
    MsgCrValue     = 4'd10
  } host_msg_e;

  // Host command opcode presented on cmd_opcode.
  typedef enum logic [1:0] {
    OpBoot       = 2'd0,
    OpEnableCore = 2'd1,
    OpReadCr     = 2'd2,
    OpWriteCr    = 2'd3
  } host_op_e;

  function automatic host_msg_e op_to_msg(host_op_e op);
    host_msg_e msg;
    msg = MsgBoot;
    unique case (op)
      OpBoot:       msg = MsgBoot;
      OpEnableCore: msg = MsgEnableCore;
      OpReadCr:     msg = MsgReadCr;
      OpWriteCr:    msg = MsgWriteCr;
    endcase
    return msg;
  endfunction

  // Opcodes that append a third word (arg1) after the argument word.
  function automatic logic op_has_arg1(host_op_e op);
    return (op == OpBoot) || (op == OpWriteCr);
  endfunction

endpackage

// File: rtl/npu_item_host_master.sv
// Host-side item master for the NPU.
// A host command is turned into a short sequence of item words: the message code,
// then arg0, then arg1 when the opcode needs it. READ_CR then waits for a single
// response item. If no item arrives within TIMEOUT_CYCLES cycles, the read
// completes with an error instead.
//
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   cmd_valid/cmd_ready        host command handshake (ready only when idle)
//   cmd_opcode/arg0/arg1       command fields, latched on acceptance
//   item_data_o/item_valid_o   outgoing item word, registered, held until item_avail_i
//   item_avail_i               NPU accepts the outgoing word this cycle
//   item_data_i/item_valid_i   incoming response item (used only while waiting)
//   item_avail_o               asserted only while waiting for a read response
//   rsp_valid/rsp_error        one-cycle completion pulse for READ_CR; error = timeout
//   rsp_data                   last read value (0 after a timeout), held between reads
module npu_item_host_master
  import npu_defines::*;
#(
  parameter int unsigned ITEM_w         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_opcode,
  input  logic [ITEM_w-1:0] cmd_arg0,
  input  logic [ITEM_w-1:0] cmd_arg1,
  output logic [ITEM_w-1:0] item_data_o,
  output logic              item_valid_o,
  input  logic              item_avail_i,
  input  logic [ITEM_w-1:0] item_data_i,
  input  logic              item_valid_i,
  output logic              item_avail_o,
  output logic              rsp_valid,
  output logic [ITEM_w-1:0] rsp_data,
  output logic              rsp_error
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSendOpcode,
    StSendArg0,
    StSendArg1,
    StWaitRsp,
    StResp
  } state_e;

  state_e            state_q, state_d;
  host_op_e          op_q, op_d;
  logic [ITEM_w-1:0] arg0_q, arg0_d;
  logic [ITEM_w-1:0] arg1_q, arg1_d;
  logic [ITEM_w-1:0] item_data_q, item_data_d;
  logic              item_valid_q, item_valid_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ITEM_w-1:0] rsp_data_q, rsp_data_d;
  logic              err_q, err_d;
  // Keeps cmd_ready low while reset is asserted and until the first clock after release.
  logic              rdy_q;
  logic [3:0]        msg_code;

  assign msg_code = op_to_msg(host_op_e'(cmd_opcode));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      op_q         <= OpBoot;
      arg0_q       <= '0;
      arg1_q       <= '0;
      item_data_q  <= '0;
      item_valid_q <= 1'b0;
      cnt_q        <= '0;
      rsp_data_q   <= '0;
      err_q        <= 1'b0;
      rdy_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      arg0_q       <= arg0_d;
      arg1_q       <= arg1_d;
      item_data_q  <= item_data_d;
      item_valid_q <= item_valid_d;
      cnt_q        <= cnt_d;
      rsp_data_q   <= rsp_data_d;
      err_q        <= err_d;
      rdy_q        <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    arg0_d       = arg0_q;
    arg1_d       = arg1_q;
    item_data_d  = item_data_q;
    item_valid_d = item_valid_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
    err_d        = err_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && rdy_q) begin
          op_d         = host_op_e'(cmd_opcode);
          arg0_d       = cmd_arg0;
          arg1_d       = cmd_arg1;
          item_data_d  = ITEM_w'(msg_code);
          item_valid_d = 1'b1;
          state_d      = StSendOpcode;
        end
      end
      StSendOpcode: begin
        if (item_avail_i) begin
          item_data_d = arg0_q;
          state_d     = StSendArg0;
        end
      end
      StSendArg0: begin
        if (item_avail_i) begin
          if (op_has_arg1(op_q)) begin
            item_data_d = arg1_q;
            state_d     = StSendArg1;
          end else begin
            item_valid_d = 1'b0;
            if (op_q == OpReadCr) begin
              cnt_d   = '0;
              state_d = StWaitRsp;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      StSendArg1: begin
        if (item_avail_i) begin
          item_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      StWaitRsp: begin
        // A response arriving in the expiry cycle wins over the timeout.
        if (item_valid_i) begin
          rsp_data_d = item_data_i;
          err_d      = 1'b0;
          state_d    = StResp;
        end else if (cnt_q == CntLast) begin
          rsp_data_d = '0;
          err_d      = 1'b1;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign cmd_ready    = (state_q == StIdle) && rdy_q;
  assign item_data_o  = item_data_q;
  assign item_valid_o = item_valid_q;
  assign item_avail_o = (state_q == StWaitRsp);
  assign rsp_valid    = (state_q == StResp);
  assign rsp_error    = (state_q == StResp) && err_q;
  assign rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_npu_item_host_master.sv
module tb_npu_item_host_master;

  localparam int W  = 32;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_opcode;
  logic [W-1:0] cmd_arg0;
  logic [W-1:0] cmd_arg1;
  logic [W-1:0] item_data_o;
  logic         item_valid_o;
  logic         item_avail_i;
  logic [W-1:0] item_data_i;
  logic         item_valid_i;
  logic         item_avail_o;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic         rsp_error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] sent_q[$];
  logic [W:0]   rsp_q[$];
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  npu_item_host_master #(
    .ITEM_w        (W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_arg0    (cmd_arg0),
    .cmd_arg1    (cmd_arg1),
    .item_data_o (item_data_o),
    .item_valid_o(item_valid_o),
    .item_avail_i(item_avail_i),
    .item_data_i (item_data_i),
    .item_valid_i(item_valid_i),
    .item_avail_o(item_avail_o),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_error   (rsp_error)
  );

  // Observed link traffic: every transferred word and every completion.
  always @(negedge clk) begin
    if (rst_n) begin
      if (item_valid_o && item_avail_i) sent_q.push_back(item_data_o);
      if (rsp_valid) rsp_q.push_back({rsp_error, rsp_data});
    end
  end

  // Reference model: word sequence a host command must produce on the link.
  task automatic build_expected(input int op, input logic [W-1:0] a0, input logic [W-1:0] a1);
    exp_q.delete();
    case (op)
      0: begin exp_q.push_back(0); exp_q.push_back(a0); exp_q.push_back(a1); end
      1: begin exp_q.push_back(2); exp_q.push_back(a0); end
      2: begin exp_q.push_back(8); exp_q.push_back(a0); end
      default: begin exp_q.push_back(9); exp_q.push_back(a0); exp_q.push_back(a1); end
    endcase
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one command and returns once it has been accepted (cycle 1 = first word).
  task automatic issue(input int op, input logic [W-1:0] a0, input logic [W-1:0] a1);
    cmd_valid  = 1'b1;
    cmd_opcode = 2'(op);
    cmd_arg0   = a0;
    cmd_arg1   = a1;
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: cmd_ready=%b want 1", cmd_ready);
    end
    next_cycle();
    cmd_valid = 1'b0;
  endtask

  // Runs one command under random link behaviour. The response to READ_CR is
  // delivered in the d-th waiting cycle (0-based). Noise is driven on
  // item_valid_i whenever item_avail_o is low.
  task automatic run_cmd(input int op, input logic [W-1:0] a0, input logic [W-1:0] a1,
                         input int d, input logic [W-1:0] rdata, input bit rand_avail,
                         output int waitk, output bit hung);
    bit accepted;
    bit done;
    waitk    = 0;
    accepted = 0;
    done     = 0;
    cmd_opcode = 2'(op);
    cmd_arg0   = a0;
    cmd_arg1   = a1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      item_avail_i = rand_avail ? ($urandom_range(0, 9) < 7) : 1'b1;
      if (item_avail_o) begin
        item_valid_i = (waitk == d);
        item_data_i  = (waitk == d) ? rdata : $urandom;
        waitk++;
      end else begin
        item_valid_i = rand_avail ? $urandom_range(0, 1) : 1'b0;
        item_data_i  = $urandom;
      end
      cmd_valid = !accepted;
      @(negedge clk);
      if (accepted && cmd_ready) done = 1;
      if (cmd_valid && cmd_ready) accepted = 1;
      next_cycle();
    end
    cmd_valid    = 1'b0;
    item_valid_i = 1'b0;
    hung         = !done;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({cmd_ready, item_valid_o, item_avail_o, rsp_valid, rsp_error} !== 5'b0 ||
        item_data_o !== '0 || rsp_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b iv=%b ia=%b rv=%b re=%b id=%h rd=%h want all 0",
               cmd_ready, item_valid_o, item_avail_o, rsp_valid, rsp_error, item_data_o,
               rsp_data);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: cmd_ready=%b want 1", cmd_ready);
    end
    next_cycle();
  endtask

  task automatic test_boot();
    logic [W-1:0] exp[3];
    exp[0] = 0; exp[1] = 3; exp[2] = 'h400;
    item_avail_i = 1'b1;
    issue(0, 3, 'h400);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (item_valid_o !== 1'b1 || item_data_o !== exp[i]) begin
        n_fail++;
        $display("FAIL boot_word%0d: valid=%b data=%h want 1/%h", i, item_valid_o,
                 item_data_o, exp[i]);
      end
      next_cycle();
    end
    @(negedge clk);
    n_tests++;
    if (item_valid_o !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL boot_done: valid=%b ready=%b want 0/1", item_valid_o, cmd_ready);
    end
    next_cycle();
  endtask

  task automatic test_enable_stall();
    logic [W-1:0] exp[3];
    logic         av[3];
    exp[0] = 2; exp[1] = 'hFF; exp[2] = 'hFF;
    av[0] = 1'b1; av[1] = 1'b0; av[2] = 1'b1;
    issue(1, 'hFF, $urandom);
    for (int i = 0; i < 3; i++) begin
      item_avail_i = av[i];
      @(negedge clk);
      n_tests++;
      if (item_valid_o !== 1'b1 || item_data_o !== exp[i]) begin
        n_fail++;
        $display("FAIL enable_stall_cyc%0d: valid=%b data=%h want 1/%h", i + 1, item_valid_o,
                 item_data_o, exp[i]);
      end
      next_cycle();
    end
    item_avail_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if (item_valid_o !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_done: valid=%b ready=%b want 0/1", item_valid_o, cmd_ready);
    end
    next_cycle();
  endtask

  task automatic test_read_cr();
    item_avail_i = 1'b1;
    issue(2, 'h10, 0);
    @(negedge clk);
    n_tests++;
    if (item_data_o !== 8 || item_avail_o !== 1'b0) begin
      n_fail++;
      $display("FAIL read_code: data=%h avail_o=%b want 8/0", item_data_o, item_avail_o);
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (item_data_o !== 'h10 || item_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL read_regid: data=%h valid=%b want 10/1", item_data_o, item_valid_o);
    end
    next_cycle();
    item_valid_i = 1'b1;
    item_data_i  = 'hCAFE;
    @(negedge clk);
    n_tests++;
    if (item_avail_o !== 1'b1 || item_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL read_wait: avail_o=%b valid=%b want 1/0", item_avail_o, item_valid_o);
    end
    next_cycle();
    item_valid_i = 1'b0;
    item_data_i  = '0;
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_data !== 'hCAFE) begin
      n_fail++;
      $display("FAIL read_rsp: valid=%b err=%b data=%h want 1/0/cafe", rsp_valid, rsp_error,
               rsp_data);
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || rsp_data !== 'hCAFE || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL read_after: valid=%b data=%h ready=%b want 0/cafe/1", rsp_valid, rsp_data,
               cmd_ready);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    int  waits;
    bit  seen;
    item_avail_i = 1'b1;
    item_valid_i = 1'b0;
    waits = 0;
    seen  = 0;
    issue(2, 'h22, 0);
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        n_tests++;
        if (waits !== TO || rsp_error !== 1'b1 || rsp_data !== '0) begin
          n_fail++;
          $display("FAIL timeout_rsp: waits=%0d err=%b data=%h want %0d/1/0", waits, rsp_error,
                   rsp_data, TO);
        end
      end else if (item_avail_o) begin
        waits++;
      end
      next_cycle();
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout_bound: no rsp_valid within 40 cycles, want one after %0d", TO);
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_data !== '0) begin
      n_fail++;
      $display("FAIL timeout_pulse: valid=%b err=%b data=%h want 0/0/0", rsp_valid, rsp_error,
               rsp_data);
    end
    next_cycle();
  endtask

  task automatic test_write_cr();
    logic [W-1:0] exp[3];
    int           avail_hi;
    exp[0] = 9; exp[1] = 5; exp[2] = 'h1234;
    avail_hi = 0;
    item_avail_i = 1'b1;
    issue(3, 5, 'h1234);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (item_avail_o) avail_hi++;
      if (i < 3) begin
        n_tests++;
        if (item_valid_o !== 1'b1 || item_data_o !== exp[i]) begin
          n_fail++;
          $display("FAIL write_word%0d: valid=%b data=%h want 1/%h", i, item_valid_o,
                   item_data_o, exp[i]);
        end
      end
      next_cycle();
    end
    n_tests++;
    if (avail_hi != 0) begin
      n_fail++;
      $display("FAIL write_avail_o: item_avail_o high %0d cycles want 0", avail_hi);
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    item_avail_i = 1'b1;
    issue(0, 'hA, 'hB);
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (item_valid_o !== 1'b0 || item_data_o !== '0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: valid=%b data=%h ready=%b want 0/0/0", item_valid_o,
               item_data_o, cmd_ready);
    end
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (item_valid_o) stray++;
      next_cycle();
    end
    @(negedge clk);
    n_tests++;
    if (stray != 0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_after: stray=%0d ready=%b want 0/1", stray, cmd_ready);
    end
    next_cycle();
  endtask

  task automatic test_priority();
    int           waitk;
    bit           hung;
    logic [W-1:0] rd;
    rd = $urandom;
    rsp_q.delete();
    run_cmd(2, 'h33, 0, TO - 1, rd, 1'b0, waitk, hung);
    n_tests++;
    if (hung || rsp_q.size() != 1 || rsp_q[0] !== {1'b0, rd}) begin
      n_fail++;
      $display("FAIL priority_rsp: hung=%b count=%0d got %h want %h", hung, rsp_q.size(),
               (rsp_q.size() > 0) ? rsp_q[0] : '0, {1'b0, rd});
    end
  endtask

  task automatic test_random();
    int           op, d, waitk, exp_wait;
    bit           hung;
    logic [W-1:0] a0, a1, rd;
    logic [W:0]   exp_rsp;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      a0 = $urandom;
      a1 = $urandom;
      rd = $urandom;
      d  = $urandom_range(0, TO + 2);
      build_expected(op, a0, a1);
      exp_rsp  = (d < TO) ? {1'b0, rd} : {1'b1, {W{1'b0}}};
      exp_wait = (op != 2) ? 0 : ((d < TO) ? d + 1 : TO);
      sent_q.delete();
      rsp_q.delete();
      run_cmd(op, a0, a1, d, rd, 1'b1, waitk, hung);
      n_tests++;
      if (hung || sent_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_words: hung=%b count=%0d want %0d (op %0d)", n, hung,
                 sent_q.size(), exp_q.size(), op);
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_tests++;
          if (sent_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rand%0d_word%0d: got %h want %h (op %0d)", n, i, sent_q[i],
                     exp_q[i], op);
          end
        end
      end
      n_tests++;
      if (waitk != exp_wait) begin
        n_fail++;
        $display("FAIL rand%0d_wait: avail_o cycles %0d want %0d (op %0d d %0d)", n, waitk,
                 exp_wait, op, d);
      end
      n_tests++;
      if (op == 2) begin
        if (rsp_q.size() != 1 || rsp_q[0] !== exp_rsp) begin
          n_fail++;
          $display("FAIL rand%0d_rsp: count=%0d got %h want 1/%h (d %0d)", n, rsp_q.size(),
                   (rsp_q.size() > 0) ? rsp_q[0] : '0, exp_rsp, d);
        end
      end else if (rsp_q.size() != 0) begin
        n_fail++;
        $display("FAIL rand%0d_norsp: count=%0d want 0 (op %0d)", n, rsp_q.size(), op);
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_opcode   = '0;
    cmd_arg0     = '0;
    cmd_arg1     = '0;
    item_avail_i = 1'b0;
    item_data_i  = '0;
    item_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_boot();
    test_enable_stall();
    test_read_cr();
    test_timeout();
    test_write_cr();
    test_reset_mid();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
